// File: rtl/encrypter_scheduler.sv
// Round-robin dispatch of plaintext blocks to the encrypter array with in-order ciphertext return.
// Dispatch 1 cycle after accept; results leave combinationally from buffers; in_ready drops while the next slot is busy, out_ready=0 holds results.
module encrypter_scheduler #(
    parameter int NUM_ENCRYPTERS     = 4,
    parameter int BLOCK_WIDTH        = 32,
    parameter int KEY_ROTATION_WIDTH = 5
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [BLOCK_WIDTH-1:0]                      in_block,
    output logic [NUM_ENCRYPTERS*BLOCK_WIDTH-1:0]        enc_data,
    output logic [NUM_ENCRYPTERS*KEY_ROTATION_WIDTH-1:0] enc_key_rotation,
    output logic [NUM_ENCRYPTERS-1:0]                   enc_program,
    input  logic [NUM_ENCRYPTERS-1:0]                   enc_ready,
    input  logic [NUM_ENCRYPTERS-1:0]                   enc_done,
    input  logic [NUM_ENCRYPTERS*BLOCK_WIDTH-1:0]        enc_result,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [BLOCK_WIDTH-1:0]                      out_block,
    output logic [$clog2(NUM_ENCRYPTERS):0]             in_flight,
    output logic                                        err_spurious_done
);

    localparam int PW = $clog2(NUM_ENCRYPTERS);

    typedef logic [PW-1:0] ptr_t;

    logic [NUM_ENCRYPTERS-1:0]     busy;
    logic [NUM_ENCRYPTERS-1:0]     res_valid;
    logic [NUM_ENCRYPTERS-1:0]     busy_nxt;
    logic [NUM_ENCRYPTERS-1:0]     res_valid_nxt;
    logic [NUM_ENCRYPTERS-1:0]     capture;
    logic [NUM_ENCRYPTERS-1:0]     spurious;
    ptr_t                          disp_ptr;
    ptr_t                          coll_ptr;
    logic [KEY_ROTATION_WIDTH-1:0] rot_ctr;

    logic [BLOCK_WIDTH-1:0]        data_q   [NUM_ENCRYPTERS];
    logic [KEY_ROTATION_WIDTH-1:0] rot_q    [NUM_ENCRYPTERS];
    logic [BLOCK_WIDTH-1:0]        res_buf  [NUM_ENCRYPTERS];
    logic [BLOCK_WIDTH-1:0]        result_s [NUM_ENCRYPTERS];

    logic accept;
    logic drain;

    for (genvar g = 0; g < NUM_ENCRYPTERS; g++) begin : g_slices
        assign enc_data[g*BLOCK_WIDTH +: BLOCK_WIDTH]                      = data_q[g];
        assign enc_key_rotation[g*KEY_ROTATION_WIDTH +: KEY_ROTATION_WIDTH] = rot_q[g];
        assign result_s[g] = enc_result[g*BLOCK_WIDTH +: BLOCK_WIDTH];
    end

    // in_ready looks only at registered busy, so a slot drained this cycle is reusable next cycle
    assign in_ready  = !busy[disp_ptr] && enc_ready[disp_ptr];
    assign accept    = in_valid && in_ready;
    assign out_valid = res_valid[coll_ptr];
    assign out_block = res_buf[coll_ptr];
    assign drain     = out_valid && out_ready;

    always_comb begin
        busy_nxt      = busy;
        res_valid_nxt = res_valid;
        capture       = '0;
        spurious      = '0;
        for (int i = 0; i < NUM_ENCRYPTERS; i++) begin
            capture[i]  = enc_done[i] && busy[i] && !res_valid[i];
            spurious[i] = enc_done[i] && !capture[i];
            if (capture[i]) begin
                res_valid_nxt[i] = 1'b1;
            end
        end
        if (accept) begin
            busy_nxt[disp_ptr] = 1'b1;
        end
        // The drained slot has res_valid set, so it can never be captured in the same cycle
        if (drain) begin
            busy_nxt[coll_ptr]      = 1'b0;
            res_valid_nxt[coll_ptr] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy              <= '0;
            res_valid         <= '0;
            disp_ptr          <= '0;
            coll_ptr          <= '0;
            rot_ctr           <= '0;
            enc_program       <= '0;
            in_flight         <= '0;
            err_spurious_done <= 1'b0;
            for (int i = 0; i < NUM_ENCRYPTERS; i++) begin
                data_q[i]  <= '0;
                rot_q[i]   <= '0;
                res_buf[i] <= '0;
            end
        end else begin
            busy        <= busy_nxt;
            res_valid   <= res_valid_nxt;
            enc_program <= '0;

            if (accept) begin
                data_q[disp_ptr]      <= in_block;
                rot_q[disp_ptr]       <= rot_ctr;
                enc_program[disp_ptr] <= 1'b1;
                disp_ptr              <= disp_ptr + 1'b1;
                rot_ctr               <= rot_ctr + 1'b1;
            end

            for (int i = 0; i < NUM_ENCRYPTERS; i++) begin
                if (capture[i]) begin
                    res_buf[i] <= result_s[i];
                end
            end

            if (drain) begin
                coll_ptr <= coll_ptr + 1'b1;
            end

            if (accept && !drain) begin
                in_flight <= in_flight + 1'b1;
            end else if (drain && !accept) begin
                in_flight <= in_flight - 1'b1;
            end

            if (|spurious) begin
                err_spurious_done <= 1'b1;
            end
        end
    end

endmodule

// File: doc/encrypter_scheduler.md
Name: encrypter_scheduler

Overview:
- Sits between the QSPI nibble-to-block assembly stage and the encrypter array.
- Hands each incoming plaintext block to the encrypters in strict round-robin order and tags it with a per-block key rotation value.
- Captures each encrypter's result and returns ciphertext blocks to the downstream output stage in the original input order.
- Each encrypter holds at most one block until its result has been consumed downstream.

Parameters:
- NUM_ENCRYPTERS, 4, number of encrypter instances; power of two, 2..16.
- BLOCK_WIDTH, 32, plaintext/ciphertext block width in bits.
- KEY_ROTATION_WIDTH, 5, width of the key rotation tag per block.

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream block available.
- in_ready  output  1  scheduler accepts block this cycle.
- in_block  input  BLOCK_WIDTH  plaintext block.
- enc_data  output  NUM_ENCRYPTERS*BLOCK_WIDTH  per-encrypter plaintext; slice i belongs to encrypter i.
- enc_key_rotation  output  NUM_ENCRYPTERS*KEY_ROTATION_WIDTH  per-encrypter rotation tag.
- enc_program  output  NUM_ENCRYPTERS  one-cycle load pulse per encrypter.
- enc_ready  input  NUM_ENCRYPTERS  encrypter i idle and able to load.
- enc_done  input  NUM_ENCRYPTERS  one-cycle result strobe per encrypter.
- enc_result  input  NUM_ENCRYPTERS*BLOCK_WIDTH  per-encrypter ciphertext, valid with enc_done[i].
- out_valid  output  1  next in-order ciphertext available.
- out_ready  input  1  downstream accepts.
- out_block  output  BLOCK_WIDTH  ciphertext block.
- in_flight  output  $clog2(NUM_ENCRYPTERS)+1  count of occupied slots.
- err_spurious_done  output  1  sticky error flag.

Behaviour:
- State per slot i: busy[i] (block dispatched, not yet drained) and res_valid[i] (result captured). Pointers: disp_ptr, coll_ptr, each log2(NUM_ENCRYPTERS) bits, wrapping modulo NUM_ENCRYPTERS. Counter: rot_ctr, KEY_ROTATION_WIDTH bits, wrapping.
- Reset: all busy/res_valid=0, disp_ptr=coll_ptr=0, rot_ctr=0, enc_data/enc_key_rotation=0, enc_program=0, out_valid=0, in_flight=0, err_spurious_done=0. Reset mid-operation discards every in-flight block and every captured result.
- in_ready is combinational: !busy[disp_ptr] && enc_ready[disp_ptr].
- Accept occurs when in_valid && in_ready. In that cycle the registers update:
  - enc_data slice[disp_ptr] <= in_block; enc_key_rotation slice[disp_ptr] <= rot_ctr.
  - enc_program[disp_ptr] <= 1 for exactly one cycle. Dispatch latency is 1 cycle after accept.
  - busy[disp_ptr] <= 1; disp_ptr++, rot_ctr++.
  - enc_data and enc_key_rotation slices hold their value until the next dispatch to that slot.
- Result capture: enc_done[i] with busy[i] && !res_valid[i] stores enc_result slice i into result buffer i and sets res_valid[i]. Multiple enc_done bits may assert in the same cycle; all are captured.
- Spurious done: enc_done[i] with !busy[i] or res_valid[i] is ignored (buffer unchanged) and sets err_spurious_done, which clears only on reset.
- Output: out_valid = res_valid[coll_ptr]; out_block = buffer[coll_ptr]; both combinational from registers.
  - On out_valid && out_ready: clear busy[coll_ptr] and res_valid[coll_ptr]; coll_ptr++.
  - Results that complete out of order wait in their buffers until coll_ptr reaches them.
- Simultaneous events:
  - Drain of slot k and accept into slot k in the same cycle: not possible, because in_ready samples registered busy. The slot is reusable from the next cycle.
  - Capture and drain of different slots in the same cycle are independent.
  - in_flight = popcount(busy), updated with the net change of that cycle (+1 accept, -1 drain, both => unchanged).
- Full: all busy => in_ready=0, in_flight=NUM_ENCRYPTERS. Empty: in_flight=0, out_valid=0.
- Rotation: rot_ctr wraps from 2^KEY_ROTATION_WIDTH-1 to 0 with no stall.

Test Plan:
- After reset, in_block=0xA5A5_0001, enc_ready=4'hF, in_valid=1 for 1 cycle -> next cycle enc_program=4'b0001, enc_data slice0=0xA5A5_0001, rotation0=0; in_flight=1.
- Out-of-order completion: dispatch blocks B0..B3, assert enc_done in order 2,0,3,1 with results R2,R0,R3,R1 -> out_block sequence R0,R1,R2,R3; out_valid stays low until R0 is captured.
- Full stall: 4 blocks in flight, no drain -> in_ready=0 with in_valid=1, no enc_program pulse; after R0 is drained, the next block dispatches to slot 0 with rotation=4.
- Rotation wrap: dispatch and drain 33 blocks -> block 32 carries rotation 0 and block 31 carries rotation 31; there is no stall at the wrap.
- Back-pressure: hold out_ready=0 with R0 captured -> out_valid=1 and out_block stable for 10 cycles; slot 0 is not reused.
- Reset with 3 blocks in flight and 2 results captured -> the cycle after reset, out_valid=0, in_flight=0, in_ready=enc_ready[0]; enc_done[1] arriving afterwards sets err_spurious_done=1.
